// File: rtl/gray_counter_receiver.sv
// gray_counter_receiver: synchronises a gray-coded counter from another clock domain and validates its forward progress.
// Ports:
//   clk, reset     destination clock, synchronous active-high reset
//   gray_in        gray-coded counter launched from the source domain
//   clear_errors   clears error_count (overrides a simultaneous increment)
//   counter_out    last accepted binary counter value
//   counter_valid  counter_out was freshly accepted this cycle
//   locked, fault  registered decodes of the tracking state
//   step_error     one-cycle pulse when a sample is rejected while locked
//   error_count    saturating count of step_error pulses
module gray_counter_receiver #(
  parameter int COUNTER_LENGTH = 64,
  parameter int MAX_STEP = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COUNTER_LENGTH-1:0] gray_in,
  input  logic                      clear_errors,
  output logic [COUNTER_LENGTH-1:0] counter_out,
  output logic                      counter_valid,
  output logic                      locked,
  output logic                      fault,
  output logic                      step_error,
  output logic [ERR_CNT_WIDTH-1:0]  error_count
);
  typedef enum logic [1:0] {ACQUIRE, LOCKED, FAULT} state_t;
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [COUNTER_LENGTH-1:0] STEP_MAX = COUNTER_LENGTH'(MAX_STEP);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
  state_t state, state_nxt;
  logic [COUNTER_LENGTH-1:0] s1, s2, cur, prev, bin, delta, co_nxt;
  logic v1, v2, cur_v, ref_v, good, lock_hit, cv_nxt, se_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic [ERR_CNT_WIDTH-1:0] ec_nxt;
  // each binary bit is the xor of all gray bits at and above it
  for (genvar i = 0; i < COUNTER_LENGTH; i++) begin : g_bin
    assign bin[i] = ^s2[COUNTER_LENGTH-1:i];
  end
  // modular distance: a wrap reads as +1, a backward step as a huge value
  assign delta = cur - prev;
  assign good = delta <= STEP_MAX;
  assign lock_hit = good && run == RUN_LAST;
  always_ff @(posedge clk) begin
    if (reset) state <= ACQUIRE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (ref_v)
      state_nxt = state == LOCKED ? (good ? LOCKED : FAULT) :
                  lock_hit ? LOCKED :
                  state == FAULT ? FAULT : ACQUIRE;
  end
  always_comb begin
    run_nxt = run;
    co_nxt = counter_out;
    cv_nxt = 1'b0;
    se_nxt = 1'b0;
    if (ref_v) begin
      run_nxt = state == LOCKED || lock_hit || !good ? '0 : run + 1'b1;
      co_nxt = (state == LOCKED ? good : lock_hit) ? cur : counter_out;
      cv_nxt = state == LOCKED ? good : lock_hit;
      se_nxt = state == LOCKED && !good;
    end
    ec_nxt = clear_errors ? '0 : se_nxt && !(&error_count) ? error_count + 1'b1 : error_count;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      cur <= '0;
      prev <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      cur_v <= 1'b0;
      ref_v <= 1'b0;
      run <= '0;
      counter_out <= '0;
      counter_valid <= 1'b0;
      locked <= 1'b0;
      fault <= 1'b0;
      step_error <= 1'b0;
      error_count <= '0;
    end else begin
      s1 <= gray_in;
      s2 <= s1;
      cur <= bin;
      v1 <= 1'b1;
      v2 <= v1;
      cur_v <= v2;
      // the newest sample always becomes the reference, so a jump re-anchors tracking
      prev <= cur_v ? cur : prev;
      ref_v <= ref_v | cur_v;
      run <= run_nxt;
      counter_out <= co_nxt;
      counter_valid <= cv_nxt;
      locked <= state_nxt == LOCKED;
      fault <= state_nxt == FAULT;
      step_error <= se_nxt;
      error_count <= ec_nxt;
    end
  end
endmodule

// File: tb/tb_gray_counter_receiver.sv
// tb_gray_counter_receiver: directed checks of the gray counter receiver at 64-bit and 8-bit configurations.
module tb_gray_counter_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [63:0] g64 = '0, co64;
  logic clr64 = 1'b0, cv64, lk64, ft64, se64;
  logic [15:0] ec64;
  logic [7:0] g8 = '0, co8;
  logic clr8 = 1'b0, cv8, lk8, ft8, se8;
  logic [1:0] ec8;
  int checks = 0;
  int fails = 0;
  gray_counter_receiver dut64 (
    .clk(clk), .reset(reset), .gray_in(g64), .clear_errors(clr64),
    .counter_out(co64), .counter_valid(cv64), .locked(lk64), .fault(ft64),
    .step_error(se64), .error_count(ec64)
  );
  gray_counter_receiver #(.COUNTER_LENGTH(8), .MAX_STEP(4), .LOCK_COUNT(4), .ERR_CNT_WIDTH(2)) dut8 (
    .clk(clk), .reset(reset), .gray_in(g8), .clear_errors(clr8),
    .counter_out(co8), .counter_valid(cv8), .locked(lk8), .fault(ft8),
    .step_error(se8), .error_count(ec8)
  );
  task automatic step64(input logic [63:0] v);
    g64 = v ^ (v >> 1);
    @(posedge clk);
    #1;
  endtask
  task automatic step8(input logic [7:0] v);
    g8 = v ^ (v >> 1);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    g64 = 64'hdead_beef_0123_4567;
    g8 = 8'h5a;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({co64, cv64, lk64, ft64, se64, ec64} !== '0) begin
      fails++;
      $display("FAIL reset64 got co=%0d st=%b ec=%0d expected all zero", co64, {lk64, cv64, ft64, se64}, ec64);
    end
    checks++;
    if ({co8, cv8, lk8, ft8, se8, ec8} !== '0) begin
      fails++;
      $display("FAIL reset8 got co=%0d st=%b ec=%0d expected all zero", co8, {lk8, cv8, ft8, se8}, ec8);
    end
    reset = 1'b0;
  endtask
  task automatic test_ramp_lock();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step64(64'(99 + i));
      checks++;
      if ({lk64, cv64, ft64, se64} !== (i >= 8 ? 4'b1100 : 4'b0000)) begin
        fails++;
        $display("FAIL ramp_status e%0d got %b expected %b", i, {lk64, cv64, ft64, se64}, (i >= 8 ? 4'b1100 : 4'b0000));
      end
      checks++;
      if (co64 !== (i >= 8 ? 64'(96 + i) : 64'd0)) begin
        fails++;
        $display("FAIL ramp_count e%0d got %0d expected %0d", i, co64, (i >= 8 ? 96 + i : 0));
      end
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step8(8'(249 + i));
      checks++;
      if ({lk8, cv8, ft8, se8} !== (i >= 8 ? 4'b1100 : 4'b0000)) begin
        fails++;
        $display("FAIL wrap_status e%0d got %b expected %b", i, {lk8, cv8, ft8, se8}, (i >= 8 ? 4'b1100 : 4'b0000));
      end
      checks++;
      if (co8 !== (i >= 8 ? 8'(246 + i) : 8'd0)) begin
        fails++;
        $display("FAIL wrap_count e%0d got %0d expected %0d", i, co8, (i >= 8 ? 8'(246 + i) : 8'd0));
      end
    end
    checks++;
    if (ec8 !== 2'd0) begin
      fails++;
      $display("FAIL wrap_errors got %0d expected 0", ec8);
    end
  endtask
  task automatic test_jump();
    logic [3:0] st;
    logic [63:0] co;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step64(i <= 8 ? 64'(992 + i) : 64'(1001 + i));
      st = i < 8 ? 4'b0000 : i <= 11 ? 4'b1100 : i == 12 ? 4'b0011 : i <= 15 ? 4'b0010 : 4'b1100;
      co = i < 8 ? 64'd0 : i <= 11 ? 64'(989 + i) : i <= 15 ? 64'd1000 : 64'd1014;
      checks++;
      if ({lk64, cv64, ft64, se64} !== st) begin
        fails++;
        $display("FAIL jump_status e%0d got %b expected %b", i, {lk64, cv64, ft64, se64}, st);
      end
      checks++;
      if (co64 !== co) begin
        fails++;
        $display("FAIL jump_count e%0d got %0d expected %0d", i, co64, co);
      end
      checks++;
      if (ec64 !== (i >= 12 ? 16'd1 : 16'd0)) begin
        fails++;
        $display("FAIL jump_errors e%0d got %0d expected %0d", i, ec64, (i >= 12 ? 1 : 0));
      end
    end
  endtask
  task automatic test_backward_stall();
    logic [3:0] st;
    logic [63:0] co;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      step64(i <= 8 ? 64'(492 + i) : i <= 13 ? 64'd500 : 64'd499);
      st = i < 8 ? 4'b0000 : i <= 16 ? 4'b1100 : 4'b0011;
      co = i < 8 ? 64'd0 : i <= 11 ? 64'(489 + i) : 64'd500;
      checks++;
      if ({lk64, cv64, ft64, se64} !== st) begin
        fails++;
        $display("FAIL stall_status e%0d got %b expected %b", i, {lk64, cv64, ft64, se64}, st);
      end
      checks++;
      if (co64 !== co) begin
        fails++;
        $display("FAIL stall_count e%0d got %0d expected %0d", i, co64, co);
      end
      checks++;
      if (ec64 !== (i == 17 ? 16'd1 : 16'd0)) begin
        fails++;
        $display("FAIL stall_errors e%0d got %0d expected %0d", i, ec64, (i == 17 ? 1 : 0));
      end
    end
  endtask
  task automatic test_saturation_clear();
    logic [7:0] v;
    v = 8'd10;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step8(v);
      v++;
    end
    for (int f = 1; f <= 5; f++) begin
      v = v + 8'd100;
      step8(v);
      for (int i = 0; i < 8; i++) begin
        v++;
        step8(v);
      end
      checks++;
      if (lk8 !== 1'b1) begin
        fail_line: begin
          fails++;
          $display("FAIL sat_relock fault%0d got %b expected 1", f, lk8);
        end
      end
      checks++;
      if (ec8 !== (f < 3 ? 2'(f) : 2'd3)) begin
        fails++;
        $display("FAIL sat_errors fault%0d got %0d expected %0d", f, ec8, (f < 3 ? f : 3));
      end
    end
    v = v + 8'd100;
    step8(v);
    v++;
    step8(v);
    v++;
    step8(v);
    clr8 = 1'b1;
    v++;
    step8(v);
    clr8 = 1'b0;
    checks++;
    if (se8 !== 1'b1) begin
      fails++;
      $display("FAIL clear_pulse got %b expected 1", se8);
    end
    checks++;
    if (ec8 !== 2'd0) begin
      fails++;
      $display("FAIL clear_errors got %0d expected 0", ec8);
    end
  endtask
  task automatic test_reset_mid_lock();
    do_reset();
    for (int i = 1; i <= 11; i++) step64(64'(1992 + i));
    checks++;
    if ({lk64, cv64, co64} !== {2'b11, 64'd2000}) begin
      fails++;
      $display("FAIL midrst_locked got lk=%b cv=%b co=%0d expected 1 1 2000", lk64, cv64, co64);
    end
    reset = 1'b1;
    step64(64'd2004);
    reset = 1'b0;
    checks++;
    if ({co64, cv64, lk64, ft64, se64, ec64} !== '0) begin
      fails++;
      $display("FAIL midrst_clear got co=%0d st=%b ec=%0d expected all zero", co64, {lk64, cv64, ft64, se64}, ec64);
    end
    for (int i = 1; i <= 8; i++) begin
      step64(64'(2004 + i));
      checks++;
      if ({lk64, cv64, ft64, se64} !== (i == 8 ? 4'b1100 : 4'b0000)) begin
        fails++;
        $display("FAIL midrst_status e%0d got %b expected %b", i, {lk64, cv64, ft64, se64}, (i == 8 ? 4'b1100 : 4'b0000));
      end
      checks++;
      if (co64 !== (i == 8 ? 64'd2009 : 64'd0)) begin
        fails++;
        $display("FAIL midrst_count e%0d got %0d expected %0d", i, co64, (i == 8 ? 2009 : 0));
      end
    end
  endtask
  initial begin
    test_reset();
    test_ramp_lock();
    test_wrap();
    test_jump();
    test_backward_stall();
    test_saturation_clear();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
